// File: rtl/bram_pkg.sv
// Shared constants, FSM encoding and sizing helper for the banked block-RAM.
package bram_pkg;

  localparam int RD_OLD    = 0;
  localparam int RD_BYPASS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } bram_state_t;

  function automatic int num_banks(input int addr_sz, input int bank_sz);
    return 1 << (addr_sz - bank_sz);
  endfunction

endpackage

// File: rtl/bram_bank.sv
// One 4 kb block: bit-masked write, enabled 1-cycle registered read, read-old on collision.
module bram_bank #(
  parameter int DATA_SZ = 16,
  parameter int BANK_SZ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [BANK_SZ-1:0] waddr,
  input  logic [DATA_SZ-1:0] wdata,
  input  logic [DATA_SZ-1:0] wmask,
  input  logic               rd_en,
  input  logic [BANK_SZ-1:0] raddr,
  output logic [DATA_SZ-1:0] rdata
);

  logic [DATA_SZ-1:0] mem_r [2**BANK_SZ];

  // Masked write: a 1 in wmask keeps the stored bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[waddr] <= (mem_r[waddr] & wmask) | (wdata & ~wmask);
    end
  end

  // Registered read; holds between reads and sees the pre-write word on collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DATA_SZ{1'b0}};
    end else if (rd_en) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/bram_banked.sv
// Deep memory tiled from 4 kb banks, with post-reset zero-fill and selectable
// read-during-write behaviour.
module bram_banked
  import bram_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 10,
  parameter int BANK_SZ = 8,
  parameter int RD_MODE = 0,
  parameter int CLEAR   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_ready,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic [DATA_SZ-1:0] i_wmask,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic               o_rd_valid
);

  localparam int NB         = num_banks(ADDR_SZ, BANK_SZ);
  localparam int BANK_IDX_W = (ADDR_SZ > BANK_SZ) ? (ADDR_SZ - BANK_SZ) : 1;
  localparam logic [ADDR_SZ-1:0] CLR_LAST = {ADDR_SZ{1'b1}};

  bram_state_t              state_r;
  logic                     ready_r;
  logic [ADDR_SZ-1:0]       clr_cnt_r;

  logic                     wr_en_s;
  logic [ADDR_SZ-1:0]       waddr_s;
  logic [DATA_SZ-1:0]       wdata_s;
  logic [DATA_SZ-1:0]       wmask_s;
  logic                     rd_acc_s;
  logic                     collide_s;
  logic [BANK_IDX_W-1:0]    wbank_s;
  logic [BANK_IDX_W-1:0]    rbank_s;

  logic                     rd_valid_r;
  logic [BANK_IDX_W-1:0]    rd_bank_r;
  logic                     collide_r;
  logic [DATA_SZ-1:0]       wdata_q_r;
  logic [DATA_SZ-1:0]       wmask_q_r;

  logic [DATA_SZ-1:0]       bank_rdata_s [NB];
  logic [DATA_SZ-1:0]       bank_out_s;
  logic [DATA_SZ-1:0]       rdata_s;

  // Reset/clear/ready sequencing; o_ready is registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= (CLEAR == 1) ? ST_CLEAR : ST_IDLE;
      ready_r   <= 1'b0;
      clr_cnt_r <= {ADDR_SZ{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_READY;
          ready_r <= 1'b1;
        end
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + {{(ADDR_SZ-1){1'b0}}, 1'b1};
          if (clr_cnt_r == CLR_LAST) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          ready_r   <= 1'b0;
          clr_cnt_r <= {ADDR_SZ{1'b0}};
        end
      endcase
    end
  end

  // Write port: the clear sweep owns it until ready, then user writes.
  always_comb begin
    wr_en_s = 1'b0;
    waddr_s = i_waddr;
    wdata_s = i_wdata;
    wmask_s = i_wmask;
    if (state_r == ST_CLEAR) begin
      wr_en_s = 1'b1;
      waddr_s = clr_cnt_r;
      wdata_s = {DATA_SZ{1'b0}};
      wmask_s = {DATA_SZ{1'b0}};
    end else begin
      wr_en_s = i_wr_en & ready_r;
    end
  end

  assign rd_acc_s  = i_rd_en & ready_r;
  assign collide_s = rd_acc_s & wr_en_s & (i_waddr == i_raddr);
  assign wbank_s   = BANK_IDX_W'(waddr_s >> BANK_SZ);
  assign rbank_s   = BANK_IDX_W'(i_raddr >> BANK_SZ);

  // Read-side state captured with each accepted read and held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_r <= 1'b0;
      rd_bank_r  <= {BANK_IDX_W{1'b0}};
      collide_r  <= 1'b0;
      wdata_q_r  <= {DATA_SZ{1'b0}};
      wmask_q_r  <= {DATA_SZ{1'b0}};
    end else begin
      rd_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rd_bank_r <= rbank_s;
        collide_r <= collide_s;
        wdata_q_r <= i_wdata;
        wmask_q_r <= i_wmask;
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    bram_bank #(
      .DATA_SZ(DATA_SZ),
      .BANK_SZ(BANK_SZ)
    ) u_bank (
      .clk  (i_clk),
      .rst  (i_rst),
      .wr_en(wr_en_s & (wbank_s == BANK_IDX_W'(b))),
      .waddr(waddr_s[BANK_SZ-1:0]),
      .wdata(wdata_s),
      .wmask(wmask_s),
      .rd_en(rd_acc_s & (rbank_s == BANK_IDX_W'(b))),
      .raddr(i_raddr[BANK_SZ-1:0]),
      .rdata(bank_rdata_s[b])
    );
  end

  // Bank mux plus optional write-through merge; all inputs are registers.
  always_comb begin
    bank_out_s = bank_rdata_s[rd_bank_r];
    if ((RD_MODE == RD_BYPASS) && collide_r) begin
      rdata_s = (bank_out_s & wmask_q_r) | (wdata_q_r & ~wmask_q_r);
    end else begin
      rdata_s = bank_out_s;
    end
  end

  assign o_ready    = ready_r;
  assign o_rd_valid = rd_valid_r;
  assign o_rdata    = rdata_s;

endmodule

// File: tb/tb_bram_banked.sv
// Scoreboard bench: dut0 = zero-fill + read-old, dut1 = no clear + write-through.
module tb_bram_banked;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1, sel;
  logic        wr_en, rd_en;
  logic [9:0]  waddr, raddr;
  logic [15:0] wdata, wmask;
  logic        ready0, ready1, v0, v1;
  logic [15:0] rdata0, rdata1;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   cnt;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_banked #(.DATA_SZ(16), .ADDR_SZ(10), .BANK_SZ(8), .RD_MODE(0), .CLEAR(1)) dut0 (
    .i_clk(clk), .i_rst(rst0), .o_ready(ready0),
    .i_wr_en(wr_en & ~sel), .i_waddr(waddr), .i_wdata(wdata), .i_wmask(wmask),
    .i_rd_en(rd_en & ~sel), .i_raddr(raddr), .o_rdata(rdata0), .o_rd_valid(v0)
  );

  bram_banked #(.DATA_SZ(16), .ADDR_SZ(10), .BANK_SZ(8), .RD_MODE(1), .CLEAR(0)) dut1 (
    .i_clk(clk), .i_rst(rst1), .o_ready(ready1),
    .i_wr_en(wr_en & sel), .i_waddr(waddr), .i_wdata(wdata), .i_wmask(wmask),
    .i_rd_en(rd_en & sel), .i_raddr(raddr), .o_rdata(rdata1), .o_rd_valid(v1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitors: every read-valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (v0) begin
      exp_t e;
      if (q0.size() == 0) begin
        check("dut0 spurious rd_valid", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("dut0 rdata", {16'd0, rdata0}, {16'd0, e.d});
        check("dut0 latency", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (v1) begin
      exp_t e;
      if (q1.size() == 0) begin
        check("dut1 spurious rd_valid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut1 rdata", {16'd0, rdata1}, {16'd0, e.d});
        check("dut1 latency", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [15:0] m);
    wr_en = 1'b1; waddr = a; wdata = d; wmask = m;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] e);
    rd_en = 1'b1; raddr = a;
    push(e);
    step();
    rd_en = 1'b0;
  endtask

  task automatic both(input logic [9:0] wa, input logic [15:0] d, input logic [15:0] m,
                      input logic [9:0] ra, input logic [15:0] e);
    wr_en = 1'b1; waddr = wa; wdata = d; wmask = m;
    rd_en = 1'b1; raddr = ra;
    push(e);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic count_ready0(input int inject_at);
    cnt = 0;
    while (!ready0 && cnt < 2000) begin
      wr_en = (cnt == inject_at); rd_en = (cnt == inject_at);
      step();
      cnt++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    waddr = 10'd0; raddr = 10'd0; wdata = 16'd0; wmask = 16'd0;
    repeat (3) step();

    check("reset ready0", {31'd0, ready0}, 32'd0);
    check("reset ready1", {31'd0, ready1}, 32'd0);
    check("reset valid0", {31'd0, v0}, 32'd0);
    check("reset rdata0", {16'd0, rdata0}, 32'd0);
    check("reset rdata1", {16'd0, rdata1}, 32'd0);

    // CLEAR=0 instance: ready one edge after release
    rst1 = 1'b0;
    check("idle ready1 before edge", {31'd0, ready1}, 32'd0);
    step();
    check("idle ready1 after 1 cycle", {31'd0, ready1}, 32'd1);

    // CLEAR=1 instance: full sweep
    rst0 = 1'b0;
    count_ready0(-1);
    check("clear cycles", cnt, 32'd1024);

    sel = 1'b0;
    rd(10'h3FF, 16'h0000);
    wr(10'h0FF, 16'hA5A5, 16'h0000);
    wr(10'h100, 16'h5A5A, 16'h0000);
    rd(10'h0FF, 16'hA5A5);
    rd(10'h100, 16'h5A5A);
    wr(10'h200, 16'hFFFF, 16'h0000);
    wr(10'h200, 16'h0000, 16'hFF00);
    rd(10'h200, 16'hFF00);
    wr(10'h042, 16'h1111, 16'h0000);
    both(10'h042, 16'h2222, 16'h0000, 10'h042, 16'h1111);
    rd(10'h042, 16'h2222);
    wr(10'h043, 16'h3333, 16'h0000);
    both(10'h044, 16'h4444, 16'h0000, 10'h043, 16'h3333);
    rd(10'h044, 16'h4444);
    wr(10'h3FF, 16'h7E57, 16'h0000);
    rd(10'h3FF, 16'h7E57);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold valid0", {31'd0, v0}, 32'd0);
      check("hold rdata0", {16'd0, rdata0}, 32'h7E57);
    end

    // Reset mid-clear restarts the sweep; requests during clear are dropped
    rst0 = 1'b1; step(); rst0 = 1'b0;
    repeat (500) step();
    check("ready0 low mid-clear", {31'd0, ready0}, 32'd0);
    rst0 = 1'b1; step(); rst0 = 1'b0;
    waddr = 10'h010; wdata = 16'hBEEF; wmask = 16'h0000; raddr = 10'h010;
    count_ready0(600);
    check("restart clear cycles", cnt, 32'd1024);
    rd(10'h010, 16'h0000);
    rd(10'h042, 16'h0000);

    // Write-through instance
    sel = 1'b1;
    wr(10'h042, 16'h1111, 16'h0000);
    both(10'h042, 16'h2222, 16'h0000, 10'h042, 16'h2222);
    rd(10'h042, 16'h2222);
    wr(10'h050, 16'h1234, 16'h0000);
    both(10'h050, 16'hABCD, 16'hFF00, 10'h050, 16'h12CD);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold valid1", {31'd0, v1}, 32'd0);
      check("hold rdata1", {16'd0, rdata1}, 32'h12CD);
    end
    rd(10'h050, 16'h12CD);

    repeat (3) step();
    check("dut0 pending reads", q0.size(), 32'd0);
    check("dut1 pending reads", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
